fifo_ctrl_16x32: RTL and testbench
==================================

# fifo_ctrl_16x32

Synchronous FIFO controller that turns a 16-deep × 32-bit dual-port memory into a first-in/first-out buffer. It sits directly upstream of the memory. It drives the memory's write-enable, read-enable and address inputs from client Push/Pop requests. It tracks occupancy and registers the memory's read data into a valid-qualified output for the downstream consumer.

## Interface
- ADDR_W, 4: memory address width; depth is 2**ADDR_W.
- AF_LEVEL, 14: Almost_full asserts when Count >= AF_LEVEL.
- AE_LEVEL, 2: Almost_empty asserts when Count <= AE_LEVEL.
- Clk  in  1  clock; all controller state updates on the rising edge.
- Rst  in  1  asynchronous active-low reset.
- Push  in  1  write request; Push_data is accepted when Push=1 and Full=0.
- Push_data  in  32  word to enqueue.
- Pop  in  1  read request; accepted when Pop=1 and Empty=0.
- Wr_en  out  1  memory write enable = Push & ~Full & Rst (combinational).
- Wr_addr  out  ADDR_W  memory write address = wr_ptr.
- Data_in  out  32  memory write data = Push_data (pass-through).
- Rd_en  out  1  memory read enable = Pop & ~Empty & Rst (combinational).
- Rd_addr  out  ADDR_W  memory read address = rd_ptr.
- Mem_rdata  in  32  memory read data, valid from the falling Clk edge of the pop cycle.
- Rd_data  out  32  registered popped word.
- Rd_valid  out  1  Rd_data holds a newly popped word (one-cycle pulse per pop).
- Full, Empty, Almost_full, Almost_empty  out  1 each  status flags, registered.
- Count  out  ADDR_W+1  current occupancy, 0..16.
- Overflow, Underflow  out  1 each  sticky error flags (see Configuration).

## Operation
- State: wr_ptr, rd_ptr (ADDR_W bits each, wrap modulo 16), Count (ADDR_W+1 bits), and the status flag registers.
- Accepted push: wr_ptr+1 at rising edge. Accepted pop: rd_ptr+1.
- Count: +1 on push only, −1 on pop only, unchanged when both or neither are accepted.
- Flags are computed from the next Count: Full = (Count==16), Empty = (Count==0).
- Simultaneous Push and Pop:
  - When Empty: the push is accepted and the pop is rejected. Count becomes 1.
  - When Full: the pop is accepted and the push is rejected. Count becomes 15.
  - Otherwise: both are accepted and Count is unchanged.
- Push while Full or Pop while Empty: ignored. No pointer, Count or memory change.
- Pointer wrap: 15→0 with no special behaviour. Full and Empty are distinguished by Count, not by pointer equality.
- Rd_data: loaded from Mem_rdata at the rising edge after an accepted pop. Holds its value otherwise.
- Rd_valid: 1 for exactly the cycle following an accepted pop, 0 otherwise.

## Timing
- Memory address and enable outputs change only after a rising edge or on Push/Pop changes. They must be stable before the following falling edge, where the memory samples them.
- Write: the word is in memory at the falling edge of the accept cycle.
- Read latency: Pop accepted in cycle N → Rd_valid=1 and Rd_data=word in cycle N+1.
- Back-to-back pops give one word per cycle.
- Push-to-pop: a word pushed in cycle N can be popped from cycle N+1, since Empty deasserts after edge N.
- Reset (async assert, any time including mid-burst):
  - wr_ptr=rd_ptr=0, Count=0.
  - Empty=1, Almost_empty=1, Full=0, Almost_full=0.
  - Rd_valid=0, Rd_data=0, Overflow=0, Underflow=0.
  - Wr_en=Rd_en=0 immediately.
  - Memory contents are not cleared and are treated as invalid.
- Reset deassertion is synchronised externally. The first accepted request is at the first rising edge with Rst=1.

## Configuration
- FIFO_ERR_FLAGS_EN defined:
  - Overflow sets on Push while Full; Underflow sets on Pop while Empty.
  - Both are sticky until reset and set at the rising edge of the offending cycle.
- Undefined: Overflow and Underflow are tied to 0 and no error logic is built.

## Test plan
- Reset then idle → Empty=1, Almost_empty=1, Count=0, Wr_en=Rd_en=0, Rd_valid=0.
- Push 0x00000001..0x00000010 (16 words), then pop 16 → Full=1 after the 16th push, Almost_full at Count=14. Rd_data sequence is 0x1..0x10, each with a Rd_valid pulse one cycle after Pop. Empty=1 at the end.
- Fill to 16, then Push 0xDEADBEEF → Wr_en=0 and Count stays 16. Overflow=1 with FIFO_ERR_FLAGS_EN, 0 without. Pop from empty → Rd_en=0, Rd_valid stays 0, Underflow per macro.
- Fill to 8, then 20 cycles of simultaneous Push/Pop with incrementing data → Count stays 8. Pointers wrap past 15. Output order is preserved.
- Empty FIFO with Push=Pop=1, data 0xA5A5A5A5 → push only, Count=1. Next cycle Pop → Rd_data=0xA5A5A5A5.
- Assert Rst mid-burst at Count=5 → all outputs take reset values immediately. A subsequent push/pop of 0x12345678 returns 0x12345678.

Source files
------------

// File: rtl/fifo_ctrl_16x32_if.sv
// Client, memory and status signals of the 16x32 FIFO controller.
// The slave modport is the controller; the master modport is the client/memory side.
interface fifo_ctrl_16x32_if #(
  parameter int ADDR_W = 4
);
  logic              Push;
  logic [31:0]       Push_data;
  logic              Pop;
  logic              Wr_en;
  logic [ADDR_W-1:0] Wr_addr;
  logic [31:0]       Data_in;
  logic              Rd_en;
  logic [ADDR_W-1:0] Rd_addr;
  logic [31:0]       Mem_rdata;
  logic [31:0]       Rd_data;
  logic              Rd_valid;
  logic              Full;
  logic              Empty;
  logic              Almost_full;
  logic              Almost_empty;
  logic [ADDR_W:0]   Count;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output Push, Push_data, Pop, Mem_rdata,
    input  Wr_en, Wr_addr, Data_in, Rd_en, Rd_addr, Rd_data, Rd_valid,
           Full, Empty, Almost_full, Almost_empty, Count, Overflow, Underflow
  );

  modport slave (
    input  Push, Push_data, Pop, Mem_rdata,
    output Wr_en, Wr_addr, Data_in, Rd_en, Rd_addr, Rd_data, Rd_valid,
           Full, Empty, Almost_full, Almost_empty, Count, Overflow, Underflow
  );
endinterface

// File: rtl/fifo_ctrl_16x32.sv
// FIFO controller driving a 16x32 dual-port memory from Push/Pop requests.
// Define FIFO_ERR_FLAGS_EN to build the sticky Overflow/Underflow flags.
module fifo_ctrl_16x32 #(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic Clk,
  input logic Rst,
  fifo_ctrl_16x32_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic              full_q;
  logic              empty_q;
  logic              af_q;
  logic              ae_q;
  logic [31:0]       rd_data_q;
  logic              rd_valid_q;
  logic              push_acc;
  logic              pop_acc;

  // Gating by Rst drops the enables the moment reset asserts, before any edge
  assign push_acc = bus.Push & ~full_q & Rst;
  assign pop_acc  = bus.Pop & ~empty_q & Rst;

  always_comb begin
    count_nxt = count;
    if (push_acc && !pop_acc) begin
      count_nxt = count + ONE_C;
    end else if (pop_acc && !push_acc) begin
      count_nxt = count - ONE_C;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_q <= bus.Mem_rdata;
      end
      rd_valid_q <= pop_acc;
      count      <= count_nxt;
      // Flags come from the next occupancy so they are exact in the cycle they appear
      full_q     <= (count_nxt == DEPTH_C);
      empty_q    <= (count_nxt == '0);
      af_q       <= (count_nxt >= AF_C);
      ae_q       <= (count_nxt <= AE_C);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.Push && full_q) begin
        ovf_q <= 1'b1;
      end
      if (bus.Pop && empty_q) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = udf_q;
`else
  assign bus.Overflow  = 1'b0;
  assign bus.Underflow = 1'b0;
`endif

  assign bus.Wr_en        = push_acc;
  assign bus.Wr_addr      = wr_ptr;
  assign bus.Data_in      = bus.Push_data;
  assign bus.Rd_en        = pop_acc;
  assign bus.Rd_addr      = rd_ptr;
  assign bus.Rd_data      = rd_data_q;
  assign bus.Rd_valid     = rd_valid_q;
  assign bus.Full         = full_q;
  assign bus.Empty        = empty_q;
  assign bus.Almost_full  = af_q;
  assign bus.Almost_empty = ae_q;
  assign bus.Count        = count;

endmodule

// File: tb/tb_fifo_ctrl_16x32.sv
// Directed bench for fifo_ctrl_16x32 with a behavioural 16x32 memory and a
// queue-based scoreboard of pushed words and expected popped words.
module tb_fifo_ctrl_16x32;

  logic Clk;
  logic Rst;

  fifo_ctrl_16x32_if #(.ADDR_W(4)) bus ();

  fifo_ctrl_16x32 #(.ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory samples address/enable on the falling edge; addresses never collide
  logic [31:0] mem [16];
  always @(negedge Clk) begin
    if (bus.Rd_en) bus.Mem_rdata = mem[bus.Rd_addr];
    if (bus.Wr_en) mem[bus.Wr_addr] = bus.Data_in;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_count  = 0;
  logic        m_ovf    = 1'b0;
  logic        m_udf    = 1'b0;
  logic [31:0] m_q[$];
  logic [31:0] exp_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, " count"}, 32'(bus.Count), 32'(m_count));
    checkOutput({tag, " full"}, 32'(bus.Full), 32'(m_count == 16));
    checkOutput({tag, " empty"}, 32'(bus.Empty), 32'(m_count == 0));
    checkOutput({tag, " almost_full"}, 32'(bus.Almost_full), 32'(m_count >= 14));
    checkOutput({tag, " almost_empty"}, 32'(bus.Almost_empty), 32'(m_count <= 2));
    checkOutput({tag, " overflow"}, 32'(bus.Overflow), 32'(m_ovf));
    checkOutput({tag, " underflow"}, 32'(bus.Underflow), 32'(m_udf));
  endtask

  // Called at posedge+1; drives one request cycle and checks its results
  task automatic applyStimulus(input string tag, input logic push, input logic [31:0] data,
                               input logic pop);
    logic push_ok;
    logic pop_ok;
    bus.Push      = push;
    bus.Push_data = data;
    bus.Pop       = pop;
    push_ok = push && (m_count < 16);
    pop_ok  = pop && (m_count > 0);
    #1;
    checkOutput({tag, " wr_en"}, 32'(bus.Wr_en), 32'(push_ok));
    checkOutput({tag, " rd_en"}, 32'(bus.Rd_en), 32'(pop_ok));
    checkOutput({tag, " data_in"}, bus.Data_in, data);
`ifdef FIFO_ERR_FLAGS_EN
    if (push && !push_ok) m_ovf = 1'b1;
    if (pop && !pop_ok) m_udf = 1'b1;
`endif
    if (push_ok) m_q.push_back(data);
    if (pop_ok) exp_q.push_back(m_q.pop_front());
    m_count = m_count + int'(push_ok) - int'(pop_ok);
    @(posedge Clk);
    #1;
    bus.Push = 1'b0;
    bus.Pop  = 1'b0;
    checkOutput({tag, " rd_valid"}, 32'(bus.Rd_valid), 32'(pop_ok));
    if (pop_ok) checkOutput({tag, " rd_data"}, bus.Rd_data, exp_q.pop_front());
    checkStatus(tag);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " wr_en"}, 32'(bus.Wr_en), 32'd0);
    checkOutput({tag, " rd_en"}, 32'(bus.Rd_en), 32'd0);
    checkOutput({tag, " rd_valid"}, 32'(bus.Rd_valid), 32'd0);
    checkOutput({tag, " rd_data"}, bus.Rd_data, 32'd0);
    checkOutput({tag, " wr_addr"}, 32'(bus.Wr_addr), 32'd0);
    checkOutput({tag, " rd_addr"}, 32'(bus.Rd_addr), 32'd0);
    checkStatus(tag);
  endtask

  initial begin
    Rst           = 1'b0;
    bus.Push      = 1'b0;
    bus.Pop       = 1'b0;
    bus.Push_data = '0;

    // Reset then idle
    repeat (2) @(posedge Clk);
    #1;
    checkResetState("reset");
    Rst = 1'b1;
    applyStimulus("idle", 1'b0, 32'd0, 1'b0);

    // Fill 16 then drain 16
    $display("[TB] fill and drain");
    for (int i = 1; i <= 16; i++) applyStimulus("fill", 1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus("drain", 1'b0, 32'd0, 1'b1);

    // Push while full, pop while empty
    $display("[TB] overflow and underflow");
    for (int i = 0; i < 16; i++) applyStimulus("fill2", 1'b1, 32'h100 + 32'(i), 1'b0);
    applyStimulus("push_full", 1'b1, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus("drain2", 1'b0, 32'd0, 1'b1);
    applyStimulus("pop_empty", 1'b0, 32'd0, 1'b1);
    applyStimulus("idle2", 1'b0, 32'd0, 1'b0);

    // Steady state at 8 with simultaneous push/pop; pointers wrap
    $display("[TB] simultaneous push/pop");
    for (int i = 0; i < 8; i++) applyStimulus("fill8", 1'b1, 32'h200 + 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus("both", 1'b1, 32'h300 + 32'(i), 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus("drain8", 1'b0, 32'd0, 1'b1);

    // Simultaneous request on empty: push only
    applyStimulus("both_empty", 1'b1, 32'hA5A5A5A5, 1'b1);
    applyStimulus("pop_a5", 1'b0, 32'd0, 1'b1);

    // Reset in the middle of a burst
    $display("[TB] mid-burst reset");
    for (int i = 0; i < 5; i++) applyStimulus("fill5", 1'b1, 32'h400 + 32'(i), 1'b0);
    bus.Push      = 1'b1;
    bus.Pop       = 1'b1;
    bus.Push_data = 32'hCAFEF00D;
    Rst           = 1'b0;
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_q.delete();
    exp_q.delete();
    #1;
    checkResetState("async_reset");
    @(posedge Clk);
    #1;
    checkResetState("held_reset");
    bus.Push = 1'b0;
    bus.Pop  = 1'b0;
    Rst      = 1'b1;
    applyStimulus("post_push", 1'b1, 32'h12345678, 1'b0);
    applyStimulus("post_pop", 1'b0, 32'd0, 1'b1);
    applyStimulus("final_idle", 1'b0, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
